// File: rtl/muldiv_pkg.sv
// muldiv_pkg: definitions shared by the muldiv unit.
//   - XLEN: datapath width (fixed at 32).
//   - MUL_OP_*: RV32M multiply encodings, taken from funct3[1:0].
//   - mul_state_t: sequencing states of mul_controller.
//   - op_x_signed / op_y_signed: operand signedness for a multiply op.
package muldiv_pkg;

   localparam int XLEN = 32;

   localparam logic [1:0] MUL_OP_MUL    = 2'b00;
   localparam logic [1:0] MUL_OP_MULH   = 2'b01;
   localparam logic [1:0] MUL_OP_MULHSU = 2'b10;
   localparam logic [1:0] MUL_OP_MULHU  = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_MUL  = 2'd1,
      ST_FIX  = 2'd2,
      ST_DONE = 2'd3
   } mul_state_t;

   // The multiplicand is signed for MULH and MULHSU.
   function automatic logic op_x_signed(input logic [1:0] op);
      return (op == MUL_OP_MULH) || (op == MUL_OP_MULHSU);
   endfunction

   // The multiplier is signed for MULH only.
   function automatic logic op_y_signed(input logic [1:0] op);
      return (op == MUL_OP_MULH);
   endfunction

endpackage

// File: rtl/multiplier_32.sv
// multiplier_32: unsigned 32x32 -> 64 product datapath, purely combinational.
// Ports:
//   a_i  in  32 : unsigned multiplicand
//   b_i  in  32 : unsigned multiplier
//   p_o  out 64 : full unsigned product
module multiplier_32
   import muldiv_pkg::*;
(
   input  logic [XLEN-1:0]   a_i,
   input  logic [XLEN-1:0]   b_i,
   output logic [2*XLEN-1:0] p_o
);

   // Zero-extend both operands so the product is evaluated at full width.
   assign p_o = {{XLEN{1'b0}}, a_i} * {{XLEN{1'b0}}, b_i};

endmodule

// File: rtl/mul_controller.sv
// mul_controller: sequencing controller for the RV32M multiply path.
// Takes MUL/MULH/MULHSU/MULHU requests over valid/ready, feeds operand
// magnitudes to multiplier_32, applies two's-complement sign correction to
// the 64-bit product and returns the selected 32-bit half under backpressure.
//
// Ports:
//   clk_i          in   1 : clock, all state on rising edge
//   reset_i        in   1 : synchronous active-high reset
//   start_i        in   1 : request valid
//   op_i           in   2 : 00 MUL, 01 MULH, 10 MULHSU, 11 MULHU
//   rs1_i          in  32 : multiplicand X
//   rs2_i          in  32 : multiplier Y
//   ready_o        out  1 : request accepted when start_i & ready_o
//   flush_i        in   1 : kill any in-flight operation
//   valid_o        out  1 : result valid
//   result_o       out 32 : result, held while valid_o & ~result_ready_i
//   result_ready_i in   1 : consumer accepts when valid_o & result_ready_i
//   busy_o         out  1 : high whenever the FSM is not in IDLE
//
// Build option:
//   MUL_FUSE_CACHE_EN : adds a one-entry cache of the last X, Y, signedness
//                       class and signed product; a hit on accept jumps
//                       IDLE -> DONE. Undefined: no cache, every op runs the
//                       IDLE -> MUL -> FIX -> DONE path.
module mul_controller
   import muldiv_pkg::*;
(
   input  logic            clk_i,
   input  logic            reset_i,
   input  logic            start_i,
   input  logic [1:0]      op_i,
   input  logic [XLEN-1:0] rs1_i,
   input  logic [XLEN-1:0] rs2_i,
   output logic            ready_o,
   input  logic            flush_i,
   output logic            valid_o,
   output logic [XLEN-1:0] result_o,
   input  logic            result_ready_i,
   output logic            busy_o
);

   mul_state_t        state_q,  state_d;
   logic [1:0]        op_q,     op_d;
   logic              neg_q,    neg_d;
   logic [XLEN-1:0]   x_mag_q,  x_mag_d;
   logic [XLEN-1:0]   y_mag_q,  y_mag_d;
   logic [2*XLEN-1:0] prod_q,   prod_d;
   logic [XLEN-1:0]   result_q, result_d;

   logic              x_neg, y_neg;
   logic [XLEN-1:0]   x_mag, y_mag;
   logic [2*XLEN-1:0] mult_p;
   logic [2*XLEN-1:0] p_fix;

`ifdef MUL_FUSE_CACHE_EN
   // Raw operands of the op in flight, needed to tag the cache entry in FIX.
   logic [XLEN-1:0]   x_raw_q,     x_raw_d;
   logic [XLEN-1:0]   y_raw_q,     y_raw_d;
   logic              cache_vld_q, cache_vld_d;
   logic [XLEN-1:0]   cache_x_q,   cache_x_d;
   logic [XLEN-1:0]   cache_y_q,   cache_y_d;
   logic [1:0]        cache_cls_q, cache_cls_d;
   logic [2*XLEN-1:0] cache_p_q,   cache_p_d;
   logic              cache_hit;
   logic [XLEN-1:0]   cache_half;
`endif

   // Operand conditioning. Negating 0x8000_0000 yields 0x8000_0000, which is
   // the correct magnitude when read as unsigned.
   assign x_neg = op_x_signed(op_i) & rs1_i[XLEN-1];
   assign y_neg = op_y_signed(op_i) & rs2_i[XLEN-1];
   assign x_mag = x_neg ? (~rs1_i + 1'b1) : rs1_i;
   assign y_mag = y_neg ? (~rs2_i + 1'b1) : rs2_i;

   multiplier_32 u_multiplier_32 (
      .a_i (x_mag_q),
      .b_i (y_mag_q),
      .p_o (mult_p)
   );

   // Sign-corrected product P'.
   assign p_fix = neg_q ? (~prod_q + 1'b1) : prod_q;

`ifdef MUL_FUSE_CACHE_EN
   // The low half is sign-independent, so MUL may reuse an entry of any class.
   assign cache_hit  = cache_vld_q && (rs1_i == cache_x_q) && (rs2_i == cache_y_q) &&
                       ((op_i == cache_cls_q) || (op_i == MUL_OP_MUL));
   assign cache_half = (op_i == MUL_OP_MUL) ? cache_p_q[XLEN-1:0] : cache_p_q[2*XLEN-1:XLEN];
`endif

   always_comb begin
      state_d  = state_q;
      op_d     = op_q;
      neg_d    = neg_q;
      x_mag_d  = x_mag_q;
      y_mag_d  = y_mag_q;
      prod_d   = prod_q;
      result_d = result_q;
`ifdef MUL_FUSE_CACHE_EN
      x_raw_d     = x_raw_q;
      y_raw_d     = y_raw_q;
      cache_vld_d = cache_vld_q;
      cache_x_d   = cache_x_q;
      cache_y_d   = cache_y_q;
      cache_cls_d = cache_cls_q;
      cache_p_d   = cache_p_q;
`endif

      if (flush_i) begin
         // Flush overrides everything, including a simultaneous start.
         state_d = ST_IDLE;
      end else begin
         unique case (state_q)
            ST_IDLE: begin
               if (start_i) begin
                  // MUL keeps neg low: its low half does not depend on sign.
                  op_d    = op_i;
                  x_mag_d = x_mag;
                  y_mag_d = y_mag;
                  neg_d   = (op_i != MUL_OP_MUL) && (x_neg ^ y_neg);
                  state_d = ST_MUL;
`ifdef MUL_FUSE_CACHE_EN
                  x_raw_d = rs1_i;
                  y_raw_d = rs2_i;
                  if (cache_hit) begin
                     result_d = cache_half;
                     state_d  = ST_DONE;
                  end
`endif
               end
            end
            ST_MUL: begin
               prod_d  = mult_p;
               state_d = ST_FIX;
            end
            ST_FIX: begin
               result_d = (op_q == MUL_OP_MUL) ? p_fix[XLEN-1:0] : p_fix[2*XLEN-1:XLEN];
               state_d  = ST_DONE;
`ifdef MUL_FUSE_CACHE_EN
               cache_vld_d = 1'b1;
               cache_x_d   = x_raw_q;
               cache_y_d   = y_raw_q;
               cache_cls_d = op_q;
               cache_p_d   = p_fix;
`endif
            end
            ST_DONE: begin
               if (result_ready_i) begin
                  state_d = ST_IDLE;
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q  <= ST_IDLE;
         op_q     <= '0;
         neg_q    <= 1'b0;
         x_mag_q  <= '0;
         y_mag_q  <= '0;
         prod_q   <= '0;
         result_q <= '0;
`ifdef MUL_FUSE_CACHE_EN
         x_raw_q     <= '0;
         y_raw_q     <= '0;
         cache_vld_q <= 1'b0;
         cache_x_q   <= '0;
         cache_y_q   <= '0;
         cache_cls_q <= '0;
         cache_p_q   <= '0;
`endif
      end else begin
         state_q  <= state_d;
         op_q     <= op_d;
         neg_q    <= neg_d;
         x_mag_q  <= x_mag_d;
         y_mag_q  <= y_mag_d;
         prod_q   <= prod_d;
         result_q <= result_d;
`ifdef MUL_FUSE_CACHE_EN
         x_raw_q     <= x_raw_d;
         y_raw_q     <= y_raw_d;
         cache_vld_q <= cache_vld_d;
         cache_x_q   <= cache_x_d;
         cache_y_q   <= cache_y_d;
         cache_cls_q <= cache_cls_d;
         cache_p_q   <= cache_p_d;
`endif
      end
   end

   // All status outputs are pure decodes of the state register.
   assign ready_o  = (state_q == ST_IDLE);
   assign valid_o  = (state_q == ST_DONE);
   assign busy_o   = (state_q != ST_IDLE);
   assign result_o = result_q;

endmodule

// File: tb/tb_mul_controller.sv
// tb_mul_controller: self-checking bench for mul_controller.
// Expected results come from a sign-extension reference model and are pushed
// to a scoreboard queue when a request is driven, then popped when valid_o
// is seen. Latency is counted in rising edges starting with the edge that
// samples start_i: 3 on the normal path, 1 on a cache hit.
// Works with MUL_FUSE_CACHE_EN defined or undefined.
module tb_mul_controller;
   import muldiv_pkg::*;

   logic        clk_i = 1'b0;
   logic        reset_i = 1'b1;
   logic        start_i = 1'b0;
   logic [1:0]  op_i = 2'b00;
   logic [31:0] rs1_i = '0;
   logic [31:0] rs2_i = '0;
   logic        flush_i = 1'b0;
   logic        result_ready_i = 1'b1;
   logic        ready_o, valid_o, busy_o;
   logic [31:0] result_o;

   int errors = 0;
   int checks = 0;
   logic [31:0] exp_q[$];

`ifdef MUL_FUSE_CACHE_EN
   localparam int HIT_LAT = 1;
`else
   localparam int HIT_LAT = 3;
`endif

   always #5 clk_i = ~clk_i;

   mul_controller dut (
      .clk_i          (clk_i),
      .reset_i        (reset_i),
      .start_i        (start_i),
      .op_i           (op_i),
      .rs1_i          (rs1_i),
      .rs2_i          (rs2_i),
      .ready_o        (ready_o),
      .flush_i        (flush_i),
      .valid_o        (valid_o),
      .result_o       (result_o),
      .result_ready_i (result_ready_i),
      .busy_o         (busy_o)
   );

   // Reference: sign/zero-extend to 64 bits and multiply modulo 2^64.
   function automatic logic [31:0] ref_mul(input logic [1:0] op, input logic [31:0] x, input logic [31:0] y);
      logic [63:0] xe, ye, p;
      xe = (op == 2'b01 || op == 2'b10) ? {{32{x[31]}}, x} : {32'd0, x};
      ye = (op == 2'b01) ? {{32{y[31]}}, y} : {32'd0, y};
      p  = xe * ye;
      return (op == 2'b00) ? p[31:0] : p[63:32];
   endfunction

   // Drives one request from IDLE and waits (bounded) for valid_o.
   task automatic run_op(input logic [1:0] op, input logic [31:0] x, input logic [31:0] y,
                         output int lat, output int ready_low, output logic [31:0] res,
                         output bit timeout);
      @(negedge clk_i);
      start_i = 1'b1; op_i = op; rs1_i = x; rs2_i = y;
      exp_q.push_back(ref_mul(op, x, y));
      @(posedge clk_i); #1;
      start_i = 1'b0;
      lat = 1;
      ready_low = ready_o ? 0 : 1;
      while (!valid_o && lat < 20) begin
         @(posedge clk_i); #1;
         lat++;
         if (!ready_o) ready_low++;
      end
      timeout = !valid_o;
      res = result_o;
      if (result_ready_i) begin
         @(posedge clk_i); #1;
      end
   endtask

   task automatic test_reset();
      reset_i = 1'b1;
      repeat (2) @(posedge clk_i);
      #1;
      checks++;
      if (ready_o !== 1'b1 || valid_o !== 1'b0 || busy_o !== 1'b0 || result_o !== 32'd0) begin
         errors++;
         $display("FAIL reset_state: ready=%b valid=%b busy=%b result=%h want 1 0 0 00000000",
                  ready_o, valid_o, busy_o, result_o);
      end
      reset_i = 1'b0;
      $display("reset: ready=%b valid=%b busy=%b result=%h", ready_o, valid_o, busy_o, result_o);
   endtask

   task automatic test_mul_basic();
      int lat, rl; logic [31:0] res, e; bit to;
      run_op(2'b00, 32'h0000_0003, 32'hFFFF_FFFF, lat, rl, res, to);
      e = exp_q.pop_front();
      checks++;
      if (to) begin errors++; $display("FAIL basic_timeout: valid_o never rose"); end
      checks++;
      if (lat !== 3) begin errors++; $display("FAIL basic_latency: got %0d want 3", lat); end
      checks++;
      if (rl !== 3) begin errors++; $display("FAIL basic_ready_low: got %0d cycles want 3", rl); end
      checks++;
      if (res !== e || res !== 32'hFFFF_FFFD) begin
         errors++; $display("FAIL basic_result: got %h want %h", res, 32'hFFFF_FFFD);
      end
      $display("basic MUL 3*FFFFFFFF: result=%h lat=%0d ready_low=%0d", res, lat, rl);
   endtask

   typedef struct { logic [1:0] op; logic [31:0] x; logic [31:0] y; logic [31:0] r; } vec_t;

   task automatic test_ops();
      vec_t v[4];
      int lat, rl; logic [31:0] res, e; bit to;
      v[0] = '{2'b01, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000};
      v[1] = '{2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
      v[2] = '{2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE};
      v[3] = '{2'b01, 32'hFFFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFF};
      foreach (v[i]) begin
         run_op(v[i].op, v[i].x, v[i].y, lat, rl, res, to);
         e = exp_q.pop_front();
         checks++;
         if (to || lat !== 3) begin
            errors++; $display("FAIL op%0d_latency: got %0d timeout=%0b want 3", i, lat, to);
         end
         checks++;
         if (res !== e || res !== v[i].r) begin
            errors++; $display("FAIL op%0d_result: got %h want %h", i, res, v[i].r);
         end
         $display("op=%b x=%h y=%h result=%h lat=%0d", v[i].op, v[i].x, v[i].y, res, lat);
      end
   endtask

   task automatic test_random();
      int lat, rl; logic [31:0] res, e, x, y; logic [1:0] op; bit to;
      for (int i = 0; i < 12; i++) begin
         op = 2'($urandom_range(0, 3));
         x = $urandom;
         y = $urandom;
         if (i == 0) x = 32'h8000_0000;
         if (i == 1) y = 32'h0000_0000;
         run_op(op, x, y, lat, rl, res, to);
         e = exp_q.pop_front();
         checks++;
         if (to || res !== e) begin
            errors++; $display("FAIL random%0d: op=%b got %h want %h timeout=%0b", i, op, res, e, to);
         end
         $display("random op=%b x=%h y=%h result=%h", op, x, y, res);
      end
   endtask

   task automatic test_backpressure();
      logic [31:0] held, e; int n;
      result_ready_i = 1'b0;
      @(negedge clk_i);
      start_i = 1'b1; op_i = 2'b11; rs1_i = 32'h1234_5678; rs2_i = 32'h9ABC_DEF0;
      exp_q.push_back(ref_mul(2'b11, 32'h1234_5678, 32'h9ABC_DEF0));
      @(posedge clk_i); #1;
      // Keep start high with a different request: it must be ignored.
      op_i = 2'b00; rs1_i = 32'd7; rs2_i = 32'd9;
      n = 1;
      while (!valid_o && n < 20) begin @(posedge clk_i); #1; n++; end
      held = result_o;
      e = exp_q.pop_front();
      checks++;
      if (!valid_o || held !== e) begin
         errors++; $display("FAIL bp_result: got %h valid=%b want %h", held, valid_o, e);
      end
      for (int i = 2; i <= 6; i++) begin
         @(posedge clk_i); #1;
         checks++;
         if (valid_o !== 1'b1 || result_o !== held || ready_o !== 1'b0) begin
            errors++;
            $display("FAIL bp_hold%0d: valid=%b result=%h ready=%b want 1 %h 0",
                     i, valid_o, result_o, ready_o, held);
         end
      end
      start_i = 1'b0;
      result_ready_i = 1'b1;
      @(posedge clk_i); #1;
      checks++;
      if (ready_o !== 1'b1 || valid_o !== 1'b0) begin
         errors++; $display("FAIL bp_release: ready=%b valid=%b want 1 0", ready_o, valid_o);
      end
      $display("backpressure: held result=%h, released to IDLE ready=%b", held, ready_o);
   endtask

   task automatic test_flush();
      bit seen = 0;
      @(negedge clk_i);
      start_i = 1'b1; op_i = 2'b01; rs1_i = 32'h0000_0005; rs2_i = 32'h0000_0006;
      @(posedge clk_i); #1;
      start_i = 1'b0;
      flush_i = 1'b1;
      @(posedge clk_i); #1;
      flush_i = 1'b0;
      checks++;
      if (ready_o !== 1'b1 || valid_o !== 1'b0 || busy_o !== 1'b0) begin
         errors++; $display("FAIL flush_mul: ready=%b valid=%b busy=%b want 1 0 0", ready_o, valid_o, busy_o);
      end
      for (int i = 0; i < 5; i++) begin
         @(posedge clk_i); #1;
         if (valid_o) seen = 1;
      end
      checks++;
      if (seen) begin errors++; $display("FAIL flush_no_valid: valid=1 want 0"); end
      @(negedge clk_i);
      start_i = 1'b1; flush_i = 1'b1;
      @(posedge clk_i); #1;
      start_i = 1'b0; flush_i = 1'b0;
      checks++;
      if (ready_o !== 1'b1 || busy_o !== 1'b0) begin
         errors++; $display("FAIL flush_start: ready=%b busy=%b want 1 0", ready_o, busy_o);
      end
      $display("flush: killed in MUL, flush+start rejected, ready=%b", ready_o);
   endtask

   task automatic test_reset_mid();
      @(negedge clk_i);
      start_i = 1'b1; op_i = 2'b11; rs1_i = 32'hDEAD_BEEF; rs2_i = 32'h0000_0003;
      @(posedge clk_i); #1;
      start_i = 1'b0;
      @(posedge clk_i); #1;
      reset_i = 1'b1;
      @(posedge clk_i); #1;
      reset_i = 1'b0;
      checks++;
      if (ready_o !== 1'b1 || valid_o !== 1'b0 || busy_o !== 1'b0 || result_o !== 32'd0) begin
         errors++;
         $display("FAIL reset_in_fix: ready=%b valid=%b busy=%b result=%h want 1 0 0 00000000",
                  ready_o, valid_o, busy_o, result_o);
      end
      $display("reset in FIX: ready=%b valid=%b busy=%b result=%h", ready_o, valid_o, busy_o, result_o);
   endtask

   task automatic test_cache();
      int lat, rl; logic [31:0] res, e; bit to;
      run_op(2'b01, 32'h8000_0000, 32'h8000_0000, lat, rl, res, to);
      e = exp_q.pop_front();
      checks++;
      if (to || lat !== 3 || res !== e) begin
         errors++; $display("FAIL cache_fill: got %h lat=%0d want %h lat=3", res, lat, e);
      end
      run_op(2'b00, 32'h8000_0000, 32'h8000_0000, lat, rl, res, to);
      e = exp_q.pop_front();
      checks++;
      if (to || lat !== HIT_LAT) begin
         errors++; $display("FAIL cache_latency: got %0d want %0d", lat, HIT_LAT);
      end
      checks++;
      if (res !== e || res !== 32'h0000_0000) begin
         errors++; $display("FAIL cache_result: got %h want 00000000", res);
      end
      $display("repeat MUL after MULH: result=%h lat=%0d", res, lat);
   endtask

   task automatic test_back_to_back();
      logic [1:0] ops[4]; logic [31:0] xs[4], ys[4], e;
      int acc_cyc[4]; int n_acc = 0, n_res = 0, cyc = 0; bit acc;
      for (int i = 0; i < 4; i++) begin
         ops[i] = 2'(i); xs[i] = $urandom | 32'h1; ys[i] = $urandom + 32'(i);
      end
      result_ready_i = 1'b1;
      @(negedge clk_i);
      start_i = 1'b1; op_i = ops[0]; rs1_i = xs[0]; rs2_i = ys[0];
      exp_q.push_back(ref_mul(ops[0], xs[0], ys[0]));
      while (n_res < 4 && cyc < 60) begin
         acc = ready_o && start_i;
         if (valid_o) begin
            e = exp_q.pop_front();
            checks++;
            if (result_o !== e) begin
               errors++; $display("FAIL b2b_result%0d: got %h want %h", n_res, result_o, e);
            end
            $display("b2b result %0d: %h", n_res, result_o);
            n_res++;
         end
         @(posedge clk_i);
         cyc++;
         if (acc && n_acc < 4) begin
            acc_cyc[n_acc] = cyc;
            n_acc++;
            #1;
            if (n_acc < 4) begin
               op_i = ops[n_acc]; rs1_i = xs[n_acc]; rs2_i = ys[n_acc];
               exp_q.push_back(ref_mul(ops[n_acc], xs[n_acc], ys[n_acc]));
            end else begin
               start_i = 1'b0;
            end
         end
         @(negedge clk_i);
      end
      start_i = 1'b0;
      checks++;
      if (n_res != 4 || n_acc != 4) begin
         errors++; $display("FAIL b2b_count: results=%0d accepts=%0d want 4 4", n_res, n_acc);
      end else begin
         for (int i = 1; i < 4; i++) begin
            checks++;
            if (acc_cyc[i] - acc_cyc[i-1] != 4) begin
               errors++; $display("FAIL b2b_spacing%0d: got %0d cycles want 4", i, acc_cyc[i] - acc_cyc[i-1]);
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_mul_basic();
      test_ops();
      test_random();
      test_backpressure();
      test_flush();
      test_reset_mid();
      test_cache();
      test_back_to_back();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
